fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameters: FRAME_CYCLES, default 512, core cycles per frame (2 complex points per cycle).
REQ-002 Parameters: GAP_CYCLES, default 512, minimum cycles between successive core next pulses.
REQ-003 Parameters: TIMEOUT_CYCLES, default 4096, maximum cycles from next to next_out.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 run  in  1  level; frames start only while high.
REQ-007 fifo_level  in  11  words available in the upstream sample FIFO.
REQ-008 fifo_rd_en  out  1  FIFO pop; fifo_rd_data valid the cycle after.
REQ-009 fifo_rd_data  in  32  two 16-bit signed real samples: [15:0] even, [31:16] odd.
REQ-010 next  out  1  one-cycle frame-start pulse to the FFT core.
REQ-011 X0, X1, X2, X3  out  32 each  core inputs: X0/X2 real, X1/X3 imaginary.
REQ-012 next_out  in  1  core output-frame-start pulse.
REQ-013 Y0, Y1, Y2, Y3  in  32 each  core outputs: Y0/Y1 = bin 2k re/im, Y2/Y3 = bin 2k+1 re/im.
REQ-014 out_valid  out  1  output word valid; no backpressure.
REQ-015 out_bin  out  10  index of the even bin in the current word (0, 2, ..., 1022).
REQ-016 out_re0, out_im0, out_re1, out_im1  out  32 each  registered copies of Y0..Y3.
REQ-017 busy  out  1  high while the input state machine is outside IDLE.
REQ-018 err_overlap, err_timeout  out  1 each  sticky error flags.
REQ-019 frames_done  out  16  count of fully streamed output frames; wraps.

Function
REQ-020 Input FSM states SHALL be IDLE, LOAD and GAP.
REQ-021 IDLE->LOAD when run=1 and fifo_level>=FRAME_CYCLES; next=1 and fifo_rd_en=1 in that same cycle N.
REQ-022 fifo_rd_en SHALL be high on cycles N..N+FRAME_CYCLES-1 exactly, never stalled.
REQ-023 On cycles N+1..N+FRAME_CYCLES, X0/X2 = sign-extended even/odd sample and X1=X3=0; outside that window all X buses = 0.
REQ-024 LOAD->GAP after the last read; GAP->IDLE when the gap counter reaches GAP_CYCLES counted from cycle N.
REQ-025 Consecutive next pulses SHALL be >= GAP_CYCLES cycles apart.
REQ-026 run falling mid-frame SHALL NOT abort the frame; the FSM finishes and then holds IDLE.
REQ-027 Output FSM states SHALL be WAIT and STREAM.
REQ-028 next_out at cycle M enters STREAM; Y0..Y3 are sampled on M+1..M+FRAME_CYCLES.
REQ-029 Registered outputs appear one cycle later: out_valid high on M+2..M+FRAME_CYCLES+1.
REQ-030 out_bin SHALL be 0 on the first valid word and increment by 2 per word.
REQ-031 frames_done SHALL increment on the cycle the last word is valid.
REQ-032 next_out during STREAM sets err_overlap, restarts the stream with out_bin=0, and does not increment frames_done for the truncated frame.
REQ-033 If next_out and the final sample cycle coincide, the old frame completes and counts, then the new frame starts without error.
REQ-034 Error flags clear only on reset.

Reset
REQ-035 Asynchronous reset SHALL force both FSMs to IDLE/WAIT and clear all counters.
REQ-036 During reset: next=0, fifo_rd_en=0, X*=0, out_valid=0, out_bin=0, out_* data=0, busy=0, errors=0, frames_done=0.
REQ-037 Reset mid-frame SHALL abandon the frame; the first post-reset start waits for the REQ-021 condition only.

Configuration
REQ-038 With macro FFT_SEQ_TIMEOUT_EN defined: a counter starts at each next pulse; if no next_out arrives within TIMEOUT_CYCLES, err_timeout sets and the output FSM stays in WAIT.
REQ-039 With FFT_SEQ_TIMEOUT_EN undefined: there is no timeout counter, and err_timeout is tied to 0.

Verification
REQ-040 Reset, run=1, fifo_level=512 -> next at the first post-reset edge, 512 fifo_rd_en cycles, X0 = sample j on cycle N+1+j.
REQ-041 fifo_level=511, run=1 -> no next, busy=0; raise level to 512 -> next on the following cycle.
REQ-042 Continuous run with the FIFO always full -> next pulses exactly 512 cycles apart.
REQ-043 Model next_out at M with Y0 = k on word k -> out_valid M+2..M+513, out_bin 0..1022, out_re0 = k, frames_done = 1.
REQ-044 Second next_out 100 cycles into STREAM -> err_overlap = 1, out_bin restarts at 0, frames_done unchanged.
REQ-045 FFT_SEQ_TIMEOUT_EN defined, next_out withheld for 4096 cycles -> err_timeout = 1; with the macro undefined -> err_timeout = 0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: feeds one frame of FIFO samples into a streaming FFT core
// and turns the core's output frames into an indexed, registered word stream.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   run              level enable for starting new input frames
//   fifo_level       words available upstream; a frame starts only when a full frame is present
//   fifo_rd_en       FIFO pop, high for FRAME_CYCLES consecutive cycles per frame
//   fifo_rd_data     {odd[15:0], even[15:0]} signed samples, valid the cycle after a pop
//   next             one-cycle frame-start pulse to the core
//   X0..X3           core inputs (X0/X2 real even/odd, X1/X3 imaginary = 0)
//   next_out         core output-frame-start pulse
//   Y0..Y3           core outputs (bin 2k re/im, bin 2k+1 re/im)
//   out_valid        output word valid
//   out_bin          even bin index of the current word
//   out_re0..out_im1 registered copies of Y0..Y3
//   busy             input state machine outside IDLE
//   err_overlap      sticky: new output frame arrived before the previous finished
//   err_timeout      sticky: core output frame did not follow a start in time
//   frames_done      count of fully streamed output frames (wraps)
//
// Optional feature: define FFT_SEQ_TIMEOUT_EN to enable the next->next_out timeout
// watchdog; without it err_timeout is tied low.
module fft_frame_sequencer #(
  parameter int unsigned FRAME_CYCLES   = 512,
  parameter int unsigned GAP_CYCLES     = 512,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [10:0] fifo_level,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rd_data,
  output logic        next,
  output logic [31:0] X0,
  output logic [31:0] X1,
  output logic [31:0] X2,
  output logic [31:0] X3,
  input  logic        next_out,
  input  logic [31:0] Y0,
  input  logic [31:0] Y1,
  input  logic [31:0] Y2,
  input  logic [31:0] Y3,
  output logic        out_valid,
  output logic [9:0]  out_bin,
  output logic [31:0] out_re0,
  output logic [31:0] out_im0,
  output logic [31:0] out_re1,
  output logic [31:0] out_im1,
  output logic        busy,
  output logic        err_overlap,
  output logic        err_timeout,
  output logic [15:0] frames_done
);

  localparam int unsigned SPAN   = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W  = $clog2(SPAN + 1);
  localparam int unsigned OCNT_W = $clog2(FRAME_CYCLES + 1);

  // Parameter sanity: out_bin is 10 bits and counters assume non-zero lengths
  if (FRAME_CYCLES == 0 || FRAME_CYCLES > 512) begin : g_bad_frame
    $error("FRAME_CYCLES must be in 1..512");
  end
  if (GAP_CYCLES == 0) begin : g_bad_gap
    $error("GAP_CYCLES must be non-zero");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {IN_IDLE, IN_LOAD, IN_GAP} in_state_t;
  typedef enum logic       {OUT_WAIT, OUT_STREAM}     out_state_t;

  // ---------------- input side ----------------
  in_state_t        in_state, in_state_d;
  logic [CNT_W-1:0] in_cnt, in_cnt_d;   // cycles elapsed since the frame's next pulse
  logic             next_d, rd_en_d;
  logic             rd_valid;           // fifo_rd_data holds a popped word this cycle
  logic             start_ok, last_rd, gap_done, frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state   <= IN_IDLE;
      in_cnt     <= '0;
      next       <= 1'b0;
      fifo_rd_en <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      in_state   <= in_state_d;
      in_cnt     <= in_cnt_d;
      next       <= next_d;
      fifo_rd_en <= rd_en_d;
      rd_valid   <= fifo_rd_en;
      busy       <= (in_state_d != IN_IDLE);
    end
  end

  // Next-state logic. A new frame may launch straight from LOAD/GAP on the cycle the
  // gap elapses so that back-to-back frames are exactly GAP_CYCLES apart.
  always_comb begin
    in_state_d = in_state;
    in_cnt_d   = in_cnt + CNT_W'(1);
    next_d     = 1'b0;
    rd_en_d    = 1'b0;
    start_ok   = run && (fifo_level >= 11'(FRAME_CYCLES));
    last_rd    = (in_cnt == CNT_W'(FRAME_CYCLES - 1));
    gap_done   = (in_cnt >= CNT_W'(GAP_CYCLES - 1));
    frame_end  = 1'b0;

    case (in_state)
      IN_IDLE: begin
        in_cnt_d = '0;
        if (start_ok) begin
          in_state_d = IN_LOAD;
          next_d     = 1'b1;
          rd_en_d    = 1'b1;
        end
      end
      IN_LOAD: begin
        rd_en_d = !last_rd;
        if (last_rd) begin
          if (gap_done) frame_end = 1'b1;
          else          in_state_d = IN_GAP;
        end
      end
      IN_GAP: begin
        if (gap_done) frame_end = 1'b1;
      end
      default: in_state_d = IN_IDLE;
    endcase

    if (frame_end) begin
      in_cnt_d = '0;
      if (start_ok) begin
        in_state_d = IN_LOAD;
        next_d     = 1'b1;
        rd_en_d    = 1'b1;
      end else begin
        in_state_d = IN_IDLE;
      end
    end
  end

  // Core inputs follow the FIFO read data directly (it only arrives the cycle after the pop)
  assign X0 = rd_valid ? {{16{fifo_rd_data[15]}}, fifo_rd_data[15:0]}  : 32'h0;
  assign X2 = rd_valid ? {{16{fifo_rd_data[31]}}, fifo_rd_data[31:16]} : 32'h0;
  assign X1 = 32'h0;
  assign X3 = 32'h0;

  // ---------------- output side ----------------
  out_state_t        out_state, out_state_d;
  logic [OCNT_W-1:0] wcnt, wcnt_d;      // index of the word sampled this cycle
  logic              out_valid_d, capture, word_last, frame_inc, overlap_set;
  logic [9:0]        out_bin_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state   <= OUT_WAIT;
      wcnt        <= '0;
      out_valid   <= 1'b0;
      out_bin     <= '0;
      out_re0     <= '0;
      out_im0     <= '0;
      out_re1     <= '0;
      out_im1     <= '0;
      frames_done <= '0;
      err_overlap <= 1'b0;
    end else begin
      out_state <= out_state_d;
      wcnt      <= wcnt_d;
      out_valid <= out_valid_d;
      out_bin   <= out_bin_d;
      if (capture) begin
        out_re0 <= Y0;
        out_im0 <= Y1;
        out_re1 <= Y2;
        out_im1 <= Y3;
      end
      if (frame_inc)   frames_done <= frames_done + 16'd1;
      if (overlap_set) err_overlap <= 1'b1;
    end
  end

  // A next_out on the final sample lets the old frame finish; any earlier one truncates it.
  always_comb begin
    out_state_d = out_state;
    wcnt_d      = wcnt;
    out_valid_d = 1'b0;
    out_bin_d   = out_bin;
    capture     = 1'b0;
    frame_inc   = 1'b0;
    overlap_set = 1'b0;
    word_last   = (wcnt == OCNT_W'(FRAME_CYCLES - 1));

    case (out_state)
      OUT_WAIT: begin
        if (next_out) begin
          out_state_d = OUT_STREAM;
          wcnt_d      = '0;
        end
      end
      OUT_STREAM: begin
        out_valid_d = 1'b1;
        capture     = 1'b1;
        out_bin_d   = 10'({wcnt, 1'b0});
        wcnt_d      = wcnt + OCNT_W'(1);
        if (word_last) begin
          frame_inc = 1'b1;
          if (next_out) wcnt_d = '0;
          else          out_state_d = OUT_WAIT;
        end else if (next_out) begin
          overlap_set = 1'b1;
          wcnt_d      = '0;
        end
      end
      default: out_state_d = OUT_WAIT;
    endcase
  end

  // ---------------- optional next->next_out watchdog ----------------
`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      tmo_armed   <= 1'b0;
      err_timeout <= 1'b0;
    end else if (next) begin
      tmo_armed <= 1'b1;
      tmo_cnt   <= '0;
    end else if (next_out) begin
      tmo_armed <= 1'b0;
    end else if (tmo_armed) begin
      if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_timeout <= 1'b1;
        tmo_armed   <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Testbench for fft_frame_sequencer: random FIFO/core data, frame timing derived
// from start-cycle arithmetic, output words predicted from a list of next_out cycles.
module tb_fft_frame_sequencer;

  localparam int FC  = 512;
  localparam int GAP = 512;
  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        reset, run, next_out;
  logic [10:0] fifo_level;
  logic        fifo_rd_en, next, out_valid, busy, err_overlap, err_timeout;
  logic [31:0] fifo_rd_data;
  logic [31:0] X0, X1, X2, X3, Y0, Y1, Y2, Y3;
  logic [31:0] out_re0, out_im0, out_re1, out_im1;
  logic [9:0]  out_bin;
  logic [15:0] frames_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_frames = 0;
  bit exp_ovl = 1'b0;

  fft_frame_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .fifo_level(fifo_level),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .next(next),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3), .next_out(next_out),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .out_valid(out_valid), .out_bin(out_bin),
    .out_re0(out_re0), .out_im0(out_im0), .out_re1(out_re1), .out_im1(out_im1),
    .busy(busy), .err_overlap(err_overlap), .err_timeout(err_timeout),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: a pop in one cycle presents the next word in the following cycle;
  // otherwise the data bus carries garbage.
  logic [31:0] fifo_mem [1024];
  int          fifo_ptr = 0;
  bit          pop_pending = 1'b0;

  always @(negedge clk) pop_pending = fifo_rd_en;
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      fifo_rd_data = fifo_mem[fifo_ptr % 1024];
      fifo_ptr++;
    end else begin
      fifo_rd_data = $urandom;
    end
  end

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic fill_fifo;
    for (int i = 0; i < 1024; i++) fifo_mem[i] = $urandom;
    fifo_ptr = 0;
  endtask

  task automatic wait_next(input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (next === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: next not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: busy still high after %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b1; fifo_level = 11'd512; next_out = 1'b0;
    Y0 = 32'hDEAD_BEEF; Y1 = 32'h1234_5678; Y2 = 32'hCAFE_F00D; Y3 = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({next, fifo_rd_en, out_valid, busy, err_overlap, err_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {next, fifo_rd_en, out_valid, busy, err_overlap, err_timeout});
    end
    n_cmp++;
    if ({X0, X1, X2, X3} !== 128'h0) begin
      n_fail++; $display("FAIL reset_x: got %h want 0", {X0, X1, X2, X3});
    end
    n_cmp++;
    if ({out_re0, out_im0, out_re1, out_im1} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {out_re0, out_im0, out_re1, out_im1});
    end
    n_cmp++;
    if (out_bin !== 10'd0) begin
      n_fail++; $display("FAIL reset_bin: got %0d want 0", out_bin);
    end
    n_cmp++;
    if (frames_done !== 16'd0) begin
      n_fail++; $display("FAIL reset_frames: got %0d want 0", frames_done);
    end
  endtask

  // First frame after reset; run drops mid-frame and must not abort it.
  task automatic test_single_frame;
    bit          win;
    logic [31:0] w;
    fill_fifo;
    run = 1'b1;
    fifo_level = 11'(FC + $urandom_range(0, 100));
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0; exp_ovl = 1'b0;
    for (int c = 0; c <= FC + GAP + 4; c++) begin
      @(negedge clk);
      win = (c >= 1) && (c <= FC);
      w   = win ? fifo_mem[c - 1] : 32'h0;
      n_cmp++;
      if (next !== (c == 0)) begin
        n_fail++; $display("FAIL sf_next c=%0d: got %b want %b", c, next, (c == 0));
      end
      n_cmp++;
      if (fifo_rd_en !== (c < FC)) begin
        n_fail++; $display("FAIL sf_rd_en c=%0d: got %b want %b", c, fifo_rd_en, (c < FC));
      end
      n_cmp++;
      if (busy !== (c < FC)) begin
        n_fail++; $display("FAIL sf_busy c=%0d: got %b want %b", c, busy, (c < FC));
      end
      n_cmp++;
      if (X0 !== (win ? sx(w[15:0]) : 32'h0)) begin
        n_fail++; $display("FAIL sf_x0 c=%0d: got %h want %h", c, X0, win ? sx(w[15:0]) : 32'h0);
      end
      n_cmp++;
      if (X2 !== (win ? sx(w[31:16]) : 32'h0)) begin
        n_fail++; $display("FAIL sf_x2 c=%0d: got %h want %h", c, X2, win ? sx(w[31:16]) : 32'h0);
      end
      n_cmp++;
      if ({X1, X3} !== 64'h0) begin
        n_fail++; $display("FAIL sf_x13 c=%0d: got %h want 0", c, {X1, X3});
      end
      fifo_level = 11'(FC + $urandom_range(0, 1535));
      if (c == 100) run = 1'b0;
    end
  endtask

  // Async reset mid-frame, then the FIFO-level threshold governs the restart.
  task automatic test_reset_midframe;
    fill_fifo;
    run = 1'b1; fifo_level = 11'(FC);
    wait_next(4, "mf_start");
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({next, fifo_rd_en, busy} !== 3'b0 || X0 !== 32'h0) begin
      n_fail++; $display("FAIL mf_async: got ctl=%b x0=%h want 0", {next, fifo_rd_en, busy}, X0);
    end
    fifo_level = 11'(FC - 1);
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0; exp_ovl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (next !== 1'b0) begin
        n_fail++; $display("FAIL lvl511_next i=%0d: got %b want 0", i, next);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL lvl511_busy i=%0d: got %b want 0", i, busy);
      end
    end
    fifo_level = 11'(FC);
    @(negedge clk);
    n_cmp++;
    if (next !== 1'b1 || fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL lvl512_start: got next=%b rd=%b want 1 1", next, fifo_rd_en);
    end
    run = 1'b0;
    wait_idle(FC + GAP + 8, "mf_idle");
  endtask

  // Continuous run with a full FIFO: frames every FC cycles, reads never pause.
  task automatic test_back_to_back;
    logic [31:0] w;
    fill_fifo;
    run = 1'b1; fifo_level = 11'(FC);
    wait_next(4, "b2b_start");
    for (int c = 1; c <= 3 * FC + 10; c++) begin
      @(negedge clk);
      w = fifo_mem[(c - 1) % 1024];
      n_cmp++;
      if (next !== ((c % FC) == 0)) begin
        n_fail++; $display("FAIL b2b_next c=%0d: got %b want %b", c, next, ((c % FC) == 0));
      end
      n_cmp++;
      if (fifo_rd_en !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_rd c=%0d: got rd=%b busy=%b want 1 1", c, fifo_rd_en, busy);
      end
      n_cmp++;
      if (X0 !== sx(w[15:0])) begin
        n_fail++; $display("FAIL b2b_x0 c=%0d: got %h want %h", c, X0, sx(w[15:0]));
      end
      fifo_level = 11'(FC + $urandom_range(0, 1535));
    end
    run = 1'b0;
    wait_idle(FC + GAP + 8, "b2b_idle");
  endtask

  // Output-side model: a word sampled at cycle t belongs to the latest next_out strictly
  // before t, word index k = t - start - 1, valid while k < FC.
  int          st [4];
  int          nst;
  logic [31:0] yv0 [2048], yv1 [2048], yv2 [2048], yv3 [2048];
  bit          smp_v [2048];
  int          smp_k [2048];

  function automatic bit is_start(input int t);
    for (int j = 0; j < nst; j++) if (st[j] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_stream(input int len, input string name);
    int  s, k;
    bit  ev;
    for (int t = 0; t < len; t++) begin
      s = -1;
      for (int j = 0; j < nst; j++) if (st[j] < t) s = st[j];
      smp_v[t] = (s >= 0) && (t - s - 1 < FC);
      smp_k[t] = t - s - 1;
      yv0[t] = smp_v[t] ? 32'(smp_k[t]) : $urandom;
      yv1[t] = $urandom; yv2[t] = $urandom; yv3[t] = $urandom;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      next_out = is_start(i);
      Y0 = yv0[i]; Y1 = yv1[i]; Y2 = yv2[i]; Y3 = yv3[i];
      @(negedge clk);
      ev = (i > 0) && smp_v[i - 1];
      k  = (i > 0) ? smp_k[i - 1] : 0;
      if (ev && k == FC - 1) exp_frames++;
      if (i > 0 && is_start(i - 1) && ev && k < FC - 1) exp_ovl = 1'b1;
      n_cmp++;
      if (out_valid !== ev) begin
        n_fail++; $display("FAIL %s_valid i=%0d: got %b want %b", name, i, out_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (out_bin !== 10'(2 * k)) begin
          n_fail++; $display("FAIL %s_bin i=%0d: got %0d want %0d", name, i, out_bin, 2 * k);
        end
        n_cmp++;
        if ({out_re0, out_im0, out_re1, out_im1} !== {yv0[i-1], yv1[i-1], yv2[i-1], yv3[i-1]}) begin
          n_fail++;
          $display("FAIL %s_data i=%0d: got %h want %h", name, i,
                   {out_re0, out_im0, out_re1, out_im1}, {yv0[i-1], yv1[i-1], yv2[i-1], yv3[i-1]});
        end
      end
      n_cmp++;
      if (frames_done !== 16'(exp_frames)) begin
        n_fail++; $display("FAIL %s_frames i=%0d: got %0d want %0d", name, i, frames_done, exp_frames);
      end
      n_cmp++;
      if (err_overlap !== exp_ovl) begin
        n_fail++; $display("FAIL %s_ovl i=%0d: got %b want %b", name, i, err_overlap, exp_ovl);
      end
    end
    next_out = 1'b0;
  endtask

  task automatic test_stream_single;
    nst = 1; st[0] = 0;
    run_stream(FC + 4, "stream");
  endtask

  task automatic test_stream_chain;
    nst = 2; st[0] = 0; st[1] = FC;
    run_stream(2 * FC + 4, "chain");
  endtask

  task automatic test_overlap;
    nst = 2; st[0] = 0; st[1] = 101;
    run_stream(101 + FC + 4, "ovl");
  endtask

  task automatic test_timeout;
    bit exp_to;
    reset = 1'b1; run = 1'b0; next_out = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0; exp_ovl = 1'b0;
    fill_fifo;
    run = 1'b1; fifo_level = 11'(FC);
    wait_next(4, "tmo_start");
    run = 1'b0;
    for (int c = 1; c <= TMO + 2; c++) begin
      @(negedge clk);
`ifdef FFT_SEQ_TIMEOUT_EN
      exp_to = (c >= TMO + 1);
`else
      exp_to = 1'b0;
`endif
      n_cmp++;
      if (err_timeout !== exp_to) begin
        n_fail++; $display("FAIL tmo_flag c=%0d: got %b want %b", c, err_timeout, exp_to);
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0 || frames_done !== 16'd0) begin
      n_fail++; $display("FAIL tmo_out: got valid=%b frames=%0d want 0 0", out_valid, frames_done);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_reset_midframe;
    test_back_to_back;
    test_stream_single;
    test_stream_chain;
    test_overlap;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
